// File: rtl/tm1638_multi_ctrl.sv
// rtl/tm1638_multi_ctrl.sv - multi-board TM1638 LED&KEY display refresh and key scan controller
module tm1638_multi_ctrl #(
    parameter int CLOCK_FREQ_MHz = 12,
    parameter int TM_CLK_KHz     = 500,
    parameter int NUM_BOARDS     = 2,
    parameter int READ_WAIT_US   = 2
) (
    input  logic                     CLK,
    input  logic                     rst_n,
    input  logic [NUM_BOARDS*64-1:0] i_digits,
    input  logic [NUM_BOARDS*8-1:0]  i_leds,
    input  logic [2:0]               i_bright,
    input  logic                     i_disp_on,
    output logic [NUM_BOARDS*8-1:0]  o_keys,
    output logic                     o_frame_done,
    output logic                     o_tm_clk,
    output logic [NUM_BOARDS-1:0]    o_tm_stb,
    output logic                     o_dio_out,
    output logic                     o_dio_oe,
    input  logic                     i_dio_in
);
    localparam int HALF_RAW  = CLOCK_FREQ_MHz * 1000 / (2 * TM_CLK_KHz);
    localparam int HALF      = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int RWAIT_RAW = READ_WAIT_US * CLOCK_FREQ_MHz;
    localparam int RWAIT     = (RWAIT_RAW < 1) ? 1 : RWAIT_RAW;
    localparam int WAIT_MAX  = (2 * HALF > RWAIT) ? 2 * HALF : RWAIT;
    localparam int WW        = $clog2(WAIT_MAX);
    localparam int BW        = (NUM_BOARDS < 2) ? 1 : $clog2(NUM_BOARDS);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SETUP, S_LO, S_HI, S_RDWAIT, S_GAP
    } state_t;

    typedef enum logic [1:0] {
        C_MODE, C_DATA, C_CTRL, C_KEYS
    } cmd_t;

    state_t          state;
    cmd_t            cmd;
    logic [BW-1:0]   board;
    logic [2:0]      bit_cnt;
    logic [4:0]      byte_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [7:0]      tx_byte;
    logic [7:0]      rx_byte;
    logic [7:0]      key_acc;
    logic [63:0]     snap_digits;
    logic [7:0]      snap_leds;
    logic [2:0]      snap_bright;
    logic            snap_on;

    logic            reading;
    logic [1:0]      rd_idx;
    logic [7:0]      key_next;
    logic [7:0]      tx_first;
    logic [7:0]      tx_next;

    // Byte to send at position idx of the STB window for command c
    function automatic logic [7:0] tx_of(input cmd_t c, input logic [4:0] idx,
                                         input logic [63:0] dg, input logic [7:0] ld,
                                         input logic [2:0] br, input logic on);
        logic [3:0] addr;
        addr  = 4'(idx - 5'd1);
        tx_of = 8'h42;
        case (c)
            C_MODE: tx_of = 8'h40;
            C_DATA: begin
                if (idx == 5'd0)
                    tx_of = 8'hC0;
                else if (!addr[0])
                    tx_of = dg[{addr[3:1], 3'b000} +: 8];
                else
                    tx_of = {7'b0, ld[addr[3:1]]};
            end
            C_CTRL: tx_of = on ? {5'b10001, br} : 8'h80;
            default: tx_of = 8'h42;
        endcase
    endfunction

    // Read-phase decode and next transmit byte selection
    always_comb begin
        reading  = (cmd == C_KEYS) && (byte_cnt != 5'd0);
        rd_idx   = 2'(byte_cnt - 5'd1);
        key_next = key_acc;
        key_next[{1'b0, rd_idx}] = rx_byte[0];
        key_next[{1'b1, rd_idx}] = rx_byte[4];
        tx_first = tx_of(cmd, 5'd0, snap_digits, snap_leds, snap_bright, snap_on);
        tx_next  = tx_of(cmd, byte_cnt + 5'd1, snap_digits, snap_leds, snap_bright, snap_on);
    end

    // Sequencer: walks boards, commands, bytes and bits with registered pin outputs
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cmd          <= C_MODE;
            board        <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            wait_cnt     <= '0;
            tx_byte      <= '0;
            rx_byte      <= '0;
            key_acc      <= '0;
            snap_digits  <= '0;
            snap_leds    <= '0;
            snap_bright  <= '0;
            snap_on      <= 1'b0;
            o_keys       <= '0;
            o_frame_done <= 1'b0;
            o_tm_clk     <= 1'b1;
            o_tm_stb     <= '1;
            o_dio_out    <= 1'b1;
            o_dio_oe     <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    cmd   <= C_MODE;
                    board <= '0;
                    state <= S_START;
                end

                // Open the STB window; a board's inputs are frozen as its mode command begins
                S_START: begin
                    o_tm_stb  <= ~(NUM_BOARDS'(1) << board);
                    o_dio_oe  <= 1'b1;
                    o_dio_out <= 1'b1;
                    if (cmd == C_MODE) begin
                        snap_digits <= i_digits[{board, 6'b000000} +: 64];
                        snap_leds   <= i_leds[{board, 3'b000} +: 8];
                        snap_bright <= i_bright;
                        snap_on     <= i_disp_on;
                    end
                    tx_byte  <= tx_first;
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                    wait_cnt <= WW'(HALF - 1);
                    state    <= S_SETUP;
                end

                S_SETUP: begin
                    if (wait_cnt == '0) begin
                        o_tm_clk  <= 1'b0;
                        o_dio_out <= tx_byte[0];
                        wait_cnt  <= WW'(HALF - 1);
                        state     <= S_LO;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                S_LO: begin
                    if (wait_cnt == '0) begin
                        o_tm_clk <= 1'b1;
                        if (reading)
                            rx_byte <= {i_dio_in, rx_byte[7:1]};
                        wait_cnt <= WW'(HALF - 1);
                        state    <= S_HI;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                S_HI: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else if (bit_cnt != 3'd7) begin
                        bit_cnt  <= bit_cnt + 3'd1;
                        o_tm_clk <= 1'b0;
                        if (!reading)
                            o_dio_out <= tx_byte[bit_cnt + 3'd1];
                        wait_cnt <= WW'(HALF - 1);
                        state    <= S_LO;
                    end else begin
                        bit_cnt  <= '0;
                        byte_cnt <= byte_cnt + 5'd1;
                        if (reading) begin
                            key_acc <= key_next;
                            if (byte_cnt == 5'd4) begin
                                o_keys[{board, 3'b000} +: 8] <= key_next;
                                o_frame_done <= (board == BW'(NUM_BOARDS - 1));
                                o_tm_stb     <= '1;
                                o_dio_oe     <= 1'b1;
                                o_dio_out    <= 1'b1;
                                wait_cnt     <= WW'(2 * HALF - 1);
                                state        <= S_GAP;
                            end else begin
                                o_tm_clk <= 1'b0;
                                wait_cnt <= WW'(HALF - 1);
                                state    <= S_LO;
                            end
                        end else if (cmd == C_KEYS) begin
                            // 0x42 sent: release DIO and give the chip time to drive it
                            o_dio_oe  <= 1'b0;
                            o_dio_out <= 1'b1;
                            wait_cnt  <= WW'(RWAIT - 1);
                            state     <= S_RDWAIT;
                        end else if (cmd == C_DATA && byte_cnt != 5'd16) begin
                            tx_byte   <= tx_next;
                            o_tm_clk  <= 1'b0;
                            o_dio_out <= tx_next[0];
                            wait_cnt  <= WW'(HALF - 1);
                            state     <= S_LO;
                        end else begin
                            o_tm_stb <= '1;
                            wait_cnt <= WW'(2 * HALF - 1);
                            state    <= S_GAP;
                        end
                    end
                end

                S_RDWAIT: begin
                    if (wait_cnt == '0) begin
                        o_tm_clk <= 1'b0;
                        wait_cnt <= WW'(HALF - 1);
                        state    <= S_LO;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                // STB high gap, then advance to the next command or board
                S_GAP: begin
                    if (wait_cnt == '0) begin
                        if (cmd == C_KEYS) begin
                            cmd <= C_MODE;
                            if (board == BW'(NUM_BOARDS - 1))
                                board <= '0;
                            else
                                board <= board + 1'b1;
                        end else begin
                            cmd <= cmd_t'(cmd + 2'd1);
                        end
                        state <= S_START;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tm1638_multi_ctrl.sv
// tb/tb_tm1638_multi_ctrl.sv - scoreboard bench for tm1638_multi_ctrl with a TM1638 bus model
module tb_tm1638_multi_ctrl;
    localparam int NB   = 2;
    localparam int HALF = 12;

    logic              CLK = 1'b0;
    logic              rst_n = 1'b0;
    logic [NB*64-1:0]  i_digits;
    logic [NB*8-1:0]   i_leds;
    logic [2:0]        i_bright;
    logic              i_disp_on;
    logic [NB*8-1:0]   o_keys;
    logic              o_frame_done;
    logic              o_tm_clk;
    logic [NB-1:0]     o_tm_stb;
    logic              o_dio_out;
    logic              o_dio_oe;
    logic              i_dio_in = 1'b1;

    tm1638_multi_ctrl #(
        .CLOCK_FREQ_MHz(12), .TM_CLK_KHz(500), .NUM_BOARDS(NB), .READ_WAIT_US(2)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .i_digits(i_digits), .i_leds(i_leds),
        .i_bright(i_bright), .i_disp_on(i_disp_on), .o_keys(o_keys),
        .o_frame_done(o_frame_done), .o_tm_clk(o_tm_clk), .o_tm_stb(o_tm_stb),
        .o_dio_out(o_dio_out), .o_dio_oe(o_dio_oe), .i_dio_in(i_dio_in)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct { int b; logic [7:0] d; } byte_exp_t;
    byte_exp_t          exp_q[$];
    logic [NB*8-1:0]    keys_q[$];
    logic [7:0]         resp [NB][4];

    int vectors = 0;
    int miscompares = 0;
    int phase_err = 0;
    int phases = 0;

    logic          prev_clk = 1'b1;
    logic [NB-1:0] prev_stb = '1;
    int            run = 0;
    int            bitn = 0;
    int            byten = 0;
    int            act = -1;
    int            win = 0;
    int            oe_low = 0;
    logic [7:0]    shreg = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    task automatic note_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    task automatic push(input int b, input logic [7:0] d);
        byte_exp_t e;
        e.b = b;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Expected bus traffic for one frame from the present inputs; ctrl byte and keys are hand values
    task automatic push_frame(input logic [NB*8-1:0] keys, input logic [7:0] ctrl);
        for (int b = 0; b < NB; b++) begin
            push(b, 8'h40);
            push(b, 8'hC0);
            for (int a = 0; a < 16; a++) begin
                if (a % 2 == 1) push(b, {7'b0, i_leds[b*8 + a/2]});
                else            push(b, i_digits[b*64 + (a/2)*8 +: 8]);
            end
            push(b, ctrl);
            push(b, 8'h42);
        end
        keys_q.push_back(keys);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (!o_frame_done && n < 15000) begin
            @(negedge CLK);
            n++;
        end
        if (!o_frame_done) begin
            note_fail("frame_done_timeout");
            finish_run();
        end
        @(negedge CLK);
    endtask

    // TM1638 bus model and monitor: decodes written bytes, drives key bytes, checks timing
    always @(negedge CLK) begin
        if (o_dio_oe) oe_low = 0; else oe_low++;
        if (!rst_n) win = 0;
        if (o_tm_stb != prev_stb) begin
            bitn = 0;
            byten = 0;
            act = -1;
            if (o_tm_stb != '1) begin
                check("one_stb_low", $countones(~o_tm_stb), 1);
                for (int i = 0; i < NB; i++) if (!o_tm_stb[i]) act = i;
                win++;
            end
        end else if (act >= 0 && o_tm_clk != prev_clk) begin
            if (!o_tm_clk) begin
                if (bitn != 0) begin
                    phases++;
                    if (run != HALF) phase_err++;
                end
                if (!o_dio_oe) begin
                    if (byten == 1 && bitn == 0)
                        check("oe_low_before_read", oe_low >= 2*HALF, 1);
                    i_dio_in = resp[act][(byten-1) & 3][bitn];
                end
            end else begin
                phases++;
                if (run != HALF) phase_err++;
                if (o_dio_oe) shreg[bitn] = o_dio_out;
                bitn++;
                if (bitn == 8) begin
                    if (o_dio_oe) begin
                        if (exp_q.size() == 0) note_fail("tm_byte_unexpected");
                        else begin
                            byte_exp_t e;
                            e = exp_q.pop_front();
                            check("tm_byte {board,data}", {act[7:0], shreg}, {e.b[7:0], e.d});
                        end
                    end
                    bitn = 0;
                    byten++;
                end
            end
        end
        if (o_tm_clk != prev_clk) run = 1; else run++;
        prev_clk = o_tm_clk;
        prev_stb = o_tm_stb;
        if (o_frame_done) begin
            if (keys_q.size() == 0) note_fail("keys_unexpected_frame");
            else check("o_keys_at_frame_done", o_keys, keys_q.pop_front());
        end
    end

    initial begin
        repeat (95000) @(negedge CLK);
        note_fail("watchdog");
        finish_run();
    end

    initial begin
        int n;
        i_digits = '0;
        i_digits[7:0] = 8'h3F;
        i_digits[64+8 +: 8] = 8'hA5;
        i_digits[64+56 +: 8] = 8'h7F;
        i_leds = 16'h8108;
        i_bright = 3'd5;
        i_disp_on = 1'b1;
        for (int b = 0; b < NB; b++) for (int k = 0; k < 4; k++) resp[b][k] = 8'h00;
        resp[1][1] = 8'h10;
        resp[1][2] = 8'h01;
        rst_n = 1'b0;
        repeat (10) @(negedge CLK);
        check("reset_stb", o_tm_stb, 2'b11);
        check("reset_tm_clk", o_tm_clk, 1);
        check("reset_dio_oe", o_dio_oe, 0);
        check("reset_dio_out", o_dio_out, 1);
        check("reset_keys", o_keys, 0);
        check("reset_frame_done", o_frame_done, 0);

        // Frame 1: digit0=0x3F, LED3 on, brightness 5; board1 keys 5 and 2
        push_frame(16'h2400, 8'h8D);
        rst_n = 1'b1;
        n = 0;
        while (o_tm_stb[0] && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("stb0_first_fall", (n >= 1) && (n < 100), 1);
        wait_frame();

        // Frame 2: display off; board0 keys 0,4,7 and board1 key 6
        i_disp_on = 1'b0;
        i_bright = 3'd7;
        resp[0][0] = 8'h11;
        resp[0][3] = 8'h10;
        resp[1][1] = 8'h00;
        resp[1][2] = 8'h10;
        push_frame(16'h4091, 8'h80);
        n = 0;
        while (!(act == 0 && win % 4 == 2 && byten == 3) && n < 15000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 15000) note_fail("board0_data_wait_timeout");
        i_digits[7:0] = 8'h06;
        i_digits[56 +: 8] = 8'h5B;
        wait_frame();

        // Frame 3: new digits appear now, brightness 0
        i_disp_on = 1'b1;
        i_bright = 3'd0;
        push_frame(16'h4091, 8'h88);
        n = 0;
        while (!(act == 1 && !o_dio_oe && byten >= 2) && n < 15000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 15000) note_fail("board1_read_wait_timeout");
        rst_n = 1'b0;
        @(negedge CLK);
        check("midreset_stb", o_tm_stb, 2'b11);
        check("midreset_keys", o_keys, 0);
        check("midreset_tm_clk", o_tm_clk, 1);
        exp_q.delete();
        keys_q.delete();
        repeat (3) @(negedge CLK);

        // Frame 4: restart from board0 mode command
        push_frame(16'h4091, 8'h88);
        rst_n = 1'b1;
        wait_frame();

        check("half_period_errors", phase_err, 0);
        check("half_periods_seen", phases > 1000, 1);
        check("pending_bytes", exp_q.size(), 0);
        finish_run();
    end
endmodule
